// File: rtl/jtag_sched_pkg.sv
// jtag_sched_pkg: shared FSM states, field widths and idle pin levels for the JTAG chain scheduler.
package jtag_sched_pkg;
    typedef enum logic [2:0] {IDLE, CHK, LOW, HIGH, RESP} state_t;
    localparam int CHAIN_W = 3;
    localparam int LEN_W = 5;
    localparam logic TMS_IDLE = 1'b1;
    localparam logic TDI_IDLE = 1'b1;
endpackage

// File: rtl/jtag_rr_arbiter.sv
// jtag_rr_arbiter: round-robin grant among NUM_REQ requesters; the pointer moves past the winner on accept.
module jtag_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;

    always_comb begin
        idx_o = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = int'(ptr_q) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && req_i[c]) begin
                found = 1'b1;
                idx_o = IDX_W'(c);
            end
        end
    end

    assign any_o = |req_i;
    assign gnt_o = any_o ? NUM_REQ'(1) << idx_o : '0;
    assign ptr_d = !accept_i ? ptr_q : (int'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + IDX_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/jtag_chain_scheduler.sv
// jtag_chain_scheduler: fabric JTAG master that arbitrates requesters onto one of the
// downstream chains and shifts up to MAX_BITS TMS/TDI bits with a divided, registered TCK.
module jtag_chain_scheduler
    import jtag_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_CHAINS = 8,
    parameter int TCK_HALF   = 4,
    parameter int MAX_BITS   = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*CHAIN_W-1:0]    req_chain_i,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len_i,
    input  logic [NUM_REQ*MAX_BITS-1:0]   req_tms_i,
    input  logic [NUM_REQ*MAX_BITS-1:0]   req_tdi_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic                          rsp_err_o,
    output logic [MAX_BITS-1:0]           rsp_tdo_o,
    output logic                          busy_o,
    output logic [NUM_CHAINS-1:0]         jtag_tck_o,
    output logic [NUM_CHAINS-1:0]         jtag_tms_o,
    output logic [NUM_CHAINS-1:0]         jtag_tdi_o,
    input  logic [NUM_CHAINS-1:0]         jtag_tdo_i,
    input  logic [NUM_CHAINS-1:0]         jtag_tdo_en_i,
    output logic [NUM_CHAINS-1:0]         jtag_sel_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DIV_W = $clog2(TCK_HALF + 1);

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_oh, own_q, own_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any_req, accept;
    logic [CHAIN_W-1:0]    chain_q, chain_d;
    logic [LEN_W-1:0]      len_q, len_d, cnt_q, cnt_d;
    logic [MAX_BITS-1:0]   tms_q, tms_d, tdi_q, tdi_d, acc_q, acc_d, rsp_tdo_q, rsp_tdo_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [NUM_CHAINS-1:0] sel_q, sel_d;
    logic                  tck_q, tck_d, busy_q, busy_d, err_q, err_d, rsp_err_q, rsp_err_d;
    logic                  bit_tms_q, bit_tms_d, bit_tdi_q, bit_tdi_d;
    logic                  div_last, eff_tdo;

    jtag_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .req_i    (req_valid_i),
        .accept_i (accept),
        .any_o    (any_req),
        .gnt_o    (gnt_oh),
        .idx_o    (gnt_idx)
    );

    assign accept   = (state_q == IDLE) && any_req;
    assign div_last = div_q == DIV_W'(TCK_HALF - 1);
    assign eff_tdo  = jtag_tdo_en_i[chain_q] ? jtag_tdo_i[chain_q] : 1'b1;

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        chain_d     = chain_q;
        len_d       = len_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        tck_d       = tck_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        err_d       = err_q;
        bit_tms_d   = bit_tms_q;
        bit_tdi_d   = bit_tdi_q;
        acc_d       = acc_q;
        rsp_tdo_d   = rsp_tdo_q;
        rsp_err_d   = rsp_err_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        case (state_q)
            IDLE: if (any_req) begin
                ready_d = gnt_oh;
                own_d   = gnt_oh;
                chain_d = req_chain_i[int'(gnt_idx)*CHAIN_W +: CHAIN_W];
                len_d   = req_len_i[int'(gnt_idx)*LEN_W +: LEN_W];
                tms_d   = req_tms_i[int'(gnt_idx)*MAX_BITS +: MAX_BITS];
                tdi_d   = req_tdi_i[int'(gnt_idx)*MAX_BITS +: MAX_BITS];
                state_d = CHK;
            end
            CHK: if (int'(chain_q) >= NUM_CHAINS) begin
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                err_d     = 1'b0;
                sel_d     = NUM_CHAINS'(1) << chain_q;
                busy_d    = 1'b1;
                cnt_d     = '0;
                div_d     = '0;
                acc_d     = '0;
                bit_tms_d = tms_q[0];
                bit_tdi_d = tdi_q[0];
                state_d   = LOW;
            end
            // TDO is captured on the same edge that raises TCK
            LOW: if (div_last) begin
                div_d        = '0;
                tck_d        = 1'b1;
                acc_d[cnt_q] = eff_tdo;
                state_d      = HIGH;
            end else div_d = div_q + DIV_W'(1);
            HIGH: if (div_last) begin
                div_d = '0;
                tck_d = 1'b0;
                if (cnt_q == len_q) state_d = RESP;
                else begin
                    cnt_d     = cnt_q + LEN_W'(1);
                    bit_tms_d = tms_q[cnt_q + LEN_W'(1)];
                    bit_tdi_d = tdi_q[cnt_q + LEN_W'(1)];
                    state_d   = LOW;
                end
            end else div_d = div_q + DIV_W'(1);
            RESP: begin
                rsp_valid_d = own_q;
                rsp_tdo_d   = err_q ? '1 : acc_q;
                rsp_err_d   = err_q;
                sel_d       = '0;
                busy_d      = 1'b0;
                bit_tms_d   = TMS_IDLE;
                bit_tdi_d   = TDI_IDLE;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            own_q       <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            chain_q     <= '0;
            len_q       <= '0;
            tms_q       <= '0;
            tdi_q       <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            bit_tms_q   <= TMS_IDLE;
            bit_tdi_q   <= TDI_IDLE;
            acc_q       <= '0;
            rsp_tdo_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            chain_q     <= chain_d;
            len_q       <= len_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            bit_tms_q   <= bit_tms_d;
            bit_tdi_q   <= bit_tdi_d;
            acc_q       <= acc_d;
            rsp_tdo_q   <= rsp_tdo_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tdo_o   = rsp_tdo_q;
    assign busy_o      = busy_q;
    assign jtag_sel_o  = sel_q;
    assign jtag_tck_o  = sel_q & {NUM_CHAINS{tck_q}};
    assign jtag_tms_o  = (sel_q & {NUM_CHAINS{bit_tms_q}}) | (~sel_q & {NUM_CHAINS{TMS_IDLE}});
    assign jtag_tdi_o  = (sel_q & {NUM_CHAINS{bit_tdi_q}}) | (~sel_q & {NUM_CHAINS{TDI_IDLE}});
endmodule

// File: tb/tb_jtag_chain_scheduler.sv
// tb_jtag_chain_scheduler: scoreboard bench for jtag_chain_scheduler with TDI-to-TDO loopback chains.
module tb_jtag_chain_scheduler;
    localparam int NR = 4, NC = 6, TH = 4, MB = 32;

    logic            clk = 1'b0, rst = 1'b1;
    logic [NR-1:0]   req_valid = '0, req_ready, rsp_valid;
    logic [NR*3-1:0] req_chain = '0;
    logic [NR*5-1:0] req_len = '0;
    logic [NR*MB-1:0] req_tms = '0, req_tdi = '0;
    logic            rsp_err, busy;
    logic [MB-1:0]   rsp_tdo;
    logic [NC-1:0]   tck, tms, tdi, tdo, tdo_en = '1, sel;

    assign tdo = tdi;

    jtag_chain_scheduler #(.NUM_REQ(NR), .NUM_CHAINS(NC), .TCK_HALF(TH), .MAX_BITS(MB)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_chain_i(req_chain), .req_len_i(req_len), .req_tms_i(req_tms), .req_tdi_i(req_tdi),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_tdo_o(rsp_tdo), .busy_o(busy),
        .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
        .jtag_tdo_i(tdo), .jtag_tdo_en_i(tdo_en), .jtag_sel_o(sel)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int req; logic [31:0] tdo; logic err; int lat;} exp_t;
    exp_t    exp_q[$];
    int      grant_log[$];
    logic    tms_log[$];
    int      checks = 0, passed = 0;
    int      rises[NC];
    int      ready_cyc[NR];
    int      rearm[NR];
    int      tms_bad, idle_bad, tms_chain = -1;
    logic [NC-1:0] sel_or, tck_prev, tms_prev;

    task automatic issue(input int r, input int ch, input int len, input logic [31:0] t_ms, input logic [31:0] t_di);
        exp_t e;
        logic [31:0] mask;
        req_chain[r*3 +: 3] = 3'(ch);
        req_len[r*5 +: 5]   = 5'(len);
        req_tms[r*MB +: MB] = t_ms;
        req_tdi[r*MB +: MB] = t_di;
        req_valid[r]        = 1'b1;
        mask = (len == 31) ? 32'hFFFF_FFFF : (32'd1 << (len + 1)) - 32'd1;
        e.req = r;
        if (ch >= NC) begin
            e.tdo = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = 2;
        end else begin
            e.tdo = (tdo_en[ch] ? t_di : 32'hFFFF_FFFF) & mask;
            e.err = 1'b0;
            e.lat = 2 + (len + 1) * 2 * TH;
        end
        exp_q.push_back(e);
    endtask

    task automatic clear_obs();
        grant_log.delete();
        tms_log.delete();
        foreach (rises[c]) rises[c] = 0;
        tms_bad = 0; idle_bad = 0; sel_or = '0;
        tck_prev = tck; tms_prev = tms;
    endtask

    task automatic run(input int n, input int max);
        int got = 0, t = 0, k;
        while (got < n && t < max) begin
            @(negedge clk); t++;
            for (int c = 0; c < NC; c++) begin
                if (tck[c] && !tck_prev[c]) begin
                    rises[c]++;
                    if (c == tms_chain) tms_log.push_back(tms[c]);
                end
                if (tck[c] && tms[c] !== tms_prev[c]) tms_bad++;
                if (!sel[c] && (tck[c] || !tms[c] || !tdi[c])) idle_bad++;
            end
            sel_or |= sel; tck_prev = tck; tms_prev = tms;
            for (int r = 0; r < NR; r++) if (req_ready[r]) begin
                grant_log.push_back(r);
                ready_cyc[r] = cyc;
                req_valid[r] = 1'b0;
            end
            for (int r = 0; r < NR; r++) if (rsp_valid[r]) begin
                k = -1;
                foreach (exp_q[i]) if (k < 0 && exp_q[i].req == r) k = i;
                checks++;
                if (k < 0) $display("FAIL rsp_unexpected: response on req %0d, required none", r);
                else begin
                    passed++;
                    checks++;
                    if (rsp_tdo !== exp_q[k].tdo) $display("FAIL rsp_tdo req%0d: got %h, required %h", r, rsp_tdo, exp_q[k].tdo);
                    else passed++;
                    checks++;
                    if (rsp_err !== exp_q[k].err) $display("FAIL rsp_err req%0d: got %b, required %b", r, rsp_err, exp_q[k].err);
                    else passed++;
                    checks++;
                    if (cyc - ready_cyc[r] != exp_q[k].lat) $display("FAIL latency req%0d: got %0d, required %0d", r, cyc - ready_cyc[r], exp_q[k].lat);
                    else passed++;
                    exp_q.delete(k);
                end
                got++;
                if (rearm[r] > 0) begin
                    rearm[r]--;
                    issue(r, 1, 0, 32'h0, 32'h1);
                end
            end
        end
        checks++;
        if (got < n) $display("FAIL timeout: got %0d responses, required %0d", got, n);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== '0) $display("FAIL reset_ctrl: got %b, required 0", {req_ready, rsp_valid, rsp_err, busy});
        else passed++;
        checks++;
        if ({tck, sel} !== '0) $display("FAIL reset_tck_sel: got %h, required 0", {tck, sel});
        else passed++;
        checks++;
        if ({tms, tdi} !== '1) $display("FAIL reset_tms_tdi: got %h, required all ones", {tms, tdi});
        else passed++;
        checks++;
        if (rsp_tdo !== '0) $display("FAIL reset_tdo: got %h, required 0", rsp_tdo);
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, sel, req_ready} !== '0) $display("FAIL idle_after_reset: got %h, required 0", {busy, sel, req_ready});
        else passed++;
    endtask

    task automatic test_round_robin();
        int exp_g[4] = '{0, 1, 3, 0};
        clear_obs();
        issue(0, 1, 0, 32'h0, 32'h1);
        issue(1, 4, 0, 32'h0, 32'h0);
        issue(3, 0, 0, 32'h1, 32'h1);
        rearm[0] = 1;
        run(4, 200);
        checks++;
        if (grant_log.size() != 4) $display("FAIL rr_count: got %0d grants, required 4", grant_log.size());
        else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] != exp_g[i]) $display("FAIL rr_order[%0d]: got %0d, required %0d", i, grant_log[i], exp_g[i]);
                else passed++;
            end
        end
        checks++;
        if (idle_bad != 0) $display("FAIL rr_idle_pins: got %0d bad samples, required 0", idle_bad);
        else passed++;
    endtask

    task automatic test_loopback();
        int others = 0;
        clear_obs();
        issue(0, 2, 7, 32'h00, 32'hA5);
        run(1, 200);
        foreach (rises[c]) if (c != 2) others += rises[c];
        checks++;
        if (rises[2] != 8) $display("FAIL lb_tck_pulses: got %0d, required 8", rises[2]);
        else passed++;
        checks++;
        if (others != 0) $display("FAIL lb_other_tck: got %0d, required 0", others);
        else passed++;
        checks++;
        if (sel_or !== 6'b000100) $display("FAIL lb_sel: got %b, required 000100", sel_or);
        else passed++;
        checks++;
        if (idle_bad != 0) $display("FAIL lb_idle_pins: got %0d bad samples, required 0", idle_bad);
        else passed++;
    endtask

    task automatic test_tdo_en_off();
        tdo_en = 6'b011111;
        clear_obs();
        issue(1, 5, 31, $urandom, $urandom);
        run(1, 400);
        repeat (5) @(negedge clk);
        checks++;
        if (rsp_tdo !== 32'hFFFF_FFFF) $display("FAIL tdo_hold: got %h, required ffffffff", rsp_tdo);
        else passed++;
        tdo_en = '1;
    endtask

    task automatic test_invalid_chain();
        int total = 0;
        clear_obs();
        issue(2, 7, 3, 32'h5, 32'hA);
        run(1, 50);
        foreach (rises[c]) total += rises[c];
        checks++;
        if (total != 0 || sel_or !== '0) $display("FAIL inv_no_tck: got %0d edges sel %b, required 0", total, sel_or);
        else passed++;
    endtask

    task automatic test_tms_stream();
        int exp_t[6] = '{1, 1, 1, 1, 1, 0};
        clear_obs();
        tms_chain = 0;
        issue(3, 0, 5, 32'h1F, $urandom);
        run(1, 200);
        tms_chain = -1;
        checks++;
        if (tms_log.size() != 6) $display("FAIL tms_count: got %0d, required 6", tms_log.size());
        else begin
            passed++;
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (tms_log[i] !== 1'(exp_t[i])) $display("FAIL tms_bit[%0d]: got %b, required %0d", i, tms_log[i], exp_t[i]);
                else passed++;
            end
        end
        checks++;
        if (tms_bad != 0) $display("FAIL tms_while_high: got %0d changes, required 0", tms_bad);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int t = 0, seen = 0, nrsp = 0;
        logic prev;
        issue(0, 2, 7, $urandom, $urandom);
        prev = tck[2];
        while (seen < 4 && t < 300) begin
            @(negedge clk); t++;
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (tck[2] && !prev) seen++;
            prev = tck[2];
        end
        checks++;
        if (seen < 4) $display("FAIL mid_reach_bit3: got %0d rises, required 4", seen);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({tck, sel, busy, rsp_valid} !== '0) $display("FAIL mid_reset_ctrl: got %h, required 0", {tck, sel, busy, rsp_valid});
        else passed++;
        checks++;
        if (tms !== '1) $display("FAIL mid_reset_tms: got %b, required all ones", tms);
        else passed++;
        exp_q.delete();
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (|rsp_valid) nrsp++;
        end
        checks++;
        if (nrsp != 0) $display("FAIL mid_no_rsp: got %0d responses, required 0", nrsp);
        else passed++;
        clear_obs();
        issue(1, 3, 2, 32'h2, 32'h6);
        run(1, 200);
        checks++;
        if (rises[3] != 3) $display("FAIL post_reset_tck: got %0d, required 3", rises[3]);
        else passed++;
    endtask

    initial begin
        foreach (rearm[r]) rearm[r] = 0;
        foreach (ready_cyc[r]) ready_cyc[r] = 0;
        test_reset();
        test_round_robin();
        test_loopback();
        test_tdo_en_off();
        test_invalid_chain();
        test_tms_stream();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
